// File: rtl/mips_abb_pkg.sv
// Shared MIPS pipeline types: register/word widths, stack stop encoding, MEM-stage enums.
package mips_abb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BE_W       = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr;
  typedef logic [WORD_W-1:0]     reg_word;
  typedef logic [WORD_W-1:0]     instr_addr;
  typedef logic [BE_W-1:0]       byte_en;

  localparam reg_word ZERO   = '0;
  localparam logic    STOP   = 1'b1;
  localparam logic    NOSTOP = 1'b0;

  typedef enum logic [3:0] {
    NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
  } memop_t;

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for data memory: byte enables, store replication, load extension.
// With MEM_ALIGN_CHECK_EN defined, flags halfword/word accesses that are not naturally aligned.
module mem_align
  import mips_abb_pkg::*;
(
  input  memop_t     op,
  input  logic [1:0] lane,
  input  reg_word    wdata,
  input  reg_word    rdata,
  output byte_en     be,
  output reg_word    wdata_rep,
  output reg_word    ldata,
  output logic       is_load,
  output logic       is_store,
  output logic       misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[7:0];
    half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
    be        = '0;
    wdata_rep = wdata;
    ldata     = rdata;
    is_load   = 1'b0;
    is_store  = 1'b0;
    misalign  = 1'b0;

    unique case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    unique case (op)
      LB, LBU, SB: be = byte_en'(4'b0001 << lane);
      LH, LHU, SH: be = byte_en'(4'b0011 << {lane[1], 1'b0});
      LW, SW:      be = 4'b1111;
      default:     be = '0;
    endcase

    unique case (op)
      SB:      wdata_rep = {4{wdata[7:0]}};
      SH:      wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase

    unique case (op)
      LB:      ldata = {{24{byte_sel[7]}}, byte_sel};
      LBU:     ldata = {24'd0, byte_sel};
      LH:      ldata = {{16{half_sel[15]}}, half_sel};
      LHU:     ldata = {16'd0, half_sel};
      default: ldata = rdata;
    endcase

    is_load  = (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    is_store = (op == SB) || (op == SH) || (op == SW);

`ifdef MEM_ALIGN_CHECK_EN
    misalign = (((op == LH) || (op == LHU) || (op == SH)) && lane[0]) ||
               (((op == LW) || (op == SW)) && (lane != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: IDLE/BUSY/DONE access FSM, request holding registers, load buffer, flush drop.
// Optional MEM_ALIGN_CHECK_EN raises mem_o_adel/mem_o_ades for misaligned halfword/word accesses.
module mem_stage
  import mips_abb_pkg::*;
(
  input  logic      cpu_clk,
  input  logic      cpu_rst,
  input  logic      mem_i_rfwe,
  input  reg_addr   mem_i_rfwa,
  input  instr_addr mem_i_pc,
  input  reg_word   mem_i_alures,
  input  memop_t    mem_i_memop,
  input  reg_word   mem_i_wdata,
  input  logic      mem_i_flush,
  input  logic      stall_i,
  output logic      mem_o_rfwe,
  output reg_addr   mem_o_rfwa,
  output reg_word   mem_o_res,
  output instr_addr mem_o_pc,
  output logic      stallreq_mem,
  output logic      dm_req,
  output logic      dm_we,
  output byte_en    dm_be,
  output reg_word   dm_addr,
  output reg_word   dm_wdata,
  input  logic      dm_ack,
  input  reg_word   dm_rdata,
  output logic      mem_o_adel,
  output logic      mem_o_ades
);

  mem_state_t state_q, state_d;
  memop_t     op_q;
  reg_word    addr_q, wdata_q, ldbuf_q;
  byte_en     be_q;
  logic       we_q, rfwe_q, drop_q, drop_d;
  reg_addr    rfwa_q;
  instr_addr  pc_q;
  logic       start, capture;

  memop_t     al_op;
  logic [1:0] al_lane;
  byte_en     al_be;
  reg_word    al_wdata, al_ldata;
  logic       al_is_load, al_is_store, al_misalign;

  // In IDLE the incoming instruction is steered; afterwards the held request is.
  assign al_op   = (state_q == IDLE) ? mem_i_memop : op_q;
  assign al_lane = (state_q == IDLE) ? mem_i_alures[1:0] : addr_q[1:0];

  mem_align u_align (
    .op        (al_op),
    .lane      (al_lane),
    .wdata     (mem_i_wdata),
    .rdata     (ldbuf_q),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .ldata     (al_ldata),
    .is_load   (al_is_load),
    .is_store  (al_is_store),
    .misalign  (al_misalign)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      op_q    <= NONE;
      addr_q  <= ZERO;
      wdata_q <= ZERO;
      be_q    <= '0;
      we_q    <= 1'b0;
      rfwe_q  <= 1'b0;
      rfwa_q  <= '0;
      pc_q    <= ZERO;
      ldbuf_q <= ZERO;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (start) begin
        op_q    <= mem_i_memop;
        addr_q  <= mem_i_alures;
        wdata_q <= al_wdata;
        be_q    <= al_be;
        we_q    <= al_is_store;
        rfwe_q  <= mem_i_rfwe;
        rfwa_q  <= mem_i_rfwa;
        pc_q    <= mem_i_pc;
      end
      if (capture) ldbuf_q <= dm_rdata;
    end
  end

  // Next state and all stage outputs; reset forces every output to its idle value.
  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    start        = 1'b0;
    capture      = 1'b0;
    stallreq_mem = 1'b0;
    dm_req       = 1'b0;
    dm_we        = 1'b0;
    dm_be        = '0;
    dm_addr      = ZERO;
    dm_wdata     = ZERO;
    mem_o_rfwe   = 1'b0;
    mem_o_rfwa   = '0;
    mem_o_res    = ZERO;
    mem_o_pc     = ZERO;
    mem_o_adel   = 1'b0;
    mem_o_ades   = 1'b0;

    if (!cpu_rst) begin
      unique case (state_q)
        IDLE: begin
          drop_d = 1'b0;
          if (!mem_i_flush) begin
            mem_o_rfwa = mem_i_rfwa;
            mem_o_res  = mem_i_alures;
            mem_o_pc   = mem_i_pc;
            if (mem_i_memop == NONE) begin
              mem_o_rfwe = mem_i_rfwe;
            end else if (al_misalign) begin
              mem_o_adel = al_is_load;
              mem_o_ades = al_is_store;
            end else begin
              start        = 1'b1;
              stallreq_mem = 1'b1;
              state_d      = BUSY;
            end
          end
        end
        BUSY: begin
          // The bus is never abandoned: a flush only marks the result for dropping.
          dm_req       = 1'b1;
          dm_we        = we_q;
          dm_be        = be_q;
          dm_addr      = {addr_q[31:2], 2'b00};
          dm_wdata     = wdata_q;
          stallreq_mem = 1'b1;
          if (mem_i_flush) drop_d = 1'b1;
          if (dm_ack) begin
            capture = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (!(drop_q || mem_i_flush)) begin
            mem_o_rfwe = rfwe_q && al_is_load;
            mem_o_rfwa = rfwa_q;
            mem_o_res  = al_is_load ? al_ldata : addr_q;
            mem_o_pc   = pc_q;
          end
          state_d = ((stall_i == STOP) && !mem_i_flush) ? DONE : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized memory ops vs a reference model.
module tb_mem_stage;
  import mips_abb_pkg::*;

  logic      cpu_clk, cpu_rst;
  logic      mem_i_rfwe, mem_i_flush, stall_i;
  reg_addr   mem_i_rfwa;
  instr_addr mem_i_pc;
  reg_word   mem_i_alures, mem_i_wdata;
  memop_t    mem_i_memop;
  logic      mem_o_rfwe, stallreq_mem, dm_req, dm_we, mem_o_adel, mem_o_ades;
  reg_addr   mem_o_rfwa;
  reg_word   mem_o_res, dm_addr, dm_wdata, dm_rdata;
  instr_addr mem_o_pc;
  byte_en    dm_be;
  logic      dm_ack;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .mem_i_rfwe   (mem_i_rfwe),
    .mem_i_rfwa   (mem_i_rfwa),
    .mem_i_pc     (mem_i_pc),
    .mem_i_alures (mem_i_alures),
    .mem_i_memop  (mem_i_memop),
    .mem_i_wdata  (mem_i_wdata),
    .mem_i_flush  (mem_i_flush),
    .stall_i      (stall_i),
    .mem_o_rfwe   (mem_o_rfwe),
    .mem_o_rfwa   (mem_o_rfwa),
    .mem_o_res    (mem_o_res),
    .mem_o_pc     (mem_o_pc),
    .stallreq_mem (stallreq_mem),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_be        (dm_be),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .mem_o_adel   (mem_o_adel),
    .mem_o_ades   (mem_o_ades)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit is_ld(input memop_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic bit is_half(input memop_t op);
    return (op == LH) || (op == LHU) || (op == SH);
  endfunction

  function automatic bit is_byte(input memop_t op);
    return (op == LB) || (op == LBU) || (op == SB);
  endfunction

  // Reference model: lane arithmetic on the byte address.
  function automatic logic [3:0] exp_be(input memop_t op, input reg_word a);
    int unsigned n;
    if (is_byte(op)) n = 1 << (a % 4);
    else if (is_half(op)) n = 3 << (2 * ((a / 2) % 2));
    else n = 15;
    return 4'(n);
  endfunction

  function automatic reg_word exp_wdata(input memop_t op, input reg_word wd);
    if (op == SB) return (wd & 32'hFF) * 32'h0101_0101;
    if (op == SH) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic reg_word exp_load(input memop_t op, input reg_word a, input reg_word w);
    reg_word v;
    if (is_byte(op)) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (op == LB && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (is_half(op)) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (op == LH && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // One memory instruction from IDLE through DONE; flush_cyc < 0 means no flush,
  // hold is the number of extra DONE cycles with stall_i at STOP.
  task automatic run_op(input memop_t op, input reg_word a, input reg_word wd, input int lat,
                        input reg_word rd, input int flush_cyc, input int hold);
    reg_addr   rfwa;
    instr_addr pc;
    bit        ld, dropped;
    int        stalls;
    rfwa    = reg_addr'($urandom);
    pc      = $urandom;
    ld      = is_ld(op);
    dropped = (flush_cyc >= 0);
    @(posedge cpu_clk); #1;
    mem_i_memop = op; mem_i_alures = a; mem_i_wdata = wd;
    mem_i_rfwe = 1'b1; mem_i_rfwa = rfwa; mem_i_pc = pc;
    mem_i_flush = 1'b0; stall_i = NOSTOP;
    #1;
    stalls = int'(stallreq_mem);
    chk1("idle_stall", stallreq_mem, 1'b1);
    chk1("idle_rfwe", mem_o_rfwe, 1'b0);
    chk1("idle_req", dm_req, 1'b0);
    for (int c = 0; c <= lat; c++) begin
      @(posedge cpu_clk); #1;
      dm_ack      = (c == lat);
      dm_rdata    = (c == lat) ? rd : reg_word'($urandom);
      mem_i_flush = (c == flush_cyc);
      #1;
      stalls += int'(stallreq_mem);
      chk1("busy_req", dm_req, 1'b1);
      chk1("busy_we", dm_we, !ld);
      chk("busy_be", 32'(dm_be), 32'(exp_be(op, a)));
      chk("busy_addr", dm_addr, a & ~32'h3);
      chk1("busy_rfwe", mem_o_rfwe, 1'b0);
      if (!ld) chk("busy_wdata", dm_wdata, exp_wdata(op, wd));
    end
    chk("stall_cycles", 32'(stalls), 32'(lat + 2));
    for (int h = 0; h <= hold; h++) begin
      @(posedge cpu_clk); #1;
      dm_ack = 1'b0; mem_i_flush = 1'b0;
      stall_i = (h < hold) ? STOP : NOSTOP;
      #1;
      chk1("done_stall", stallreq_mem, 1'b0);
      chk1("done_req", dm_req, 1'b0);
      chk1("done_rfwe", mem_o_rfwe, ld && !dropped);
      if (dropped) begin
        chk("done_res_drop", mem_o_res, ZERO);
        chk("done_pc_drop", mem_o_pc, ZERO);
      end else begin
        chk("done_pc", mem_o_pc, pc);
        if (ld) begin
          chk("done_res", mem_o_res, exp_load(op, a, rd));
          chk("done_rfwa", 32'(mem_o_rfwa), 32'(rfwa));
        end
      end
    end
  endtask

  task automatic alu_step(input reg_word res, input logic we);
    @(posedge cpu_clk); #1;
    mem_i_memop = NONE; mem_i_alures = res; mem_i_rfwe = we;
    mem_i_rfwa = 5'd7; mem_i_pc = 32'h0040_0010; mem_i_flush = 1'b0; stall_i = NOSTOP;
    #1;
    chk("alu_res", mem_o_res, res);
    chk1("alu_stall", stallreq_mem, 1'b0);
    chk1("alu_rfwe", mem_o_rfwe, we);
    chk1("alu_req", dm_req, 1'b0);
  endtask

  initial begin
    memop_t ops [8];
    memop_t op;
    reg_word a;
    int fl;
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
    cpu_rst = 1'b1; mem_i_rfwe = 1'b1; mem_i_rfwa = 5'd3; mem_i_pc = 32'h100;
    mem_i_alures = 32'h1234; mem_i_memop = NONE; mem_i_wdata = '0;
    mem_i_flush = 1'b0; stall_i = NOSTOP; dm_ack = 1'b0; dm_rdata = '0;
    repeat (2) @(posedge cpu_clk);
    #2;
    chk1("rst_rfwe", mem_o_rfwe, 1'b0);
    chk("rst_res", mem_o_res, ZERO);
    chk1("rst_stall", stallreq_mem, 1'b0);
    chk1("rst_req", dm_req, 1'b0);
    chk1("rst_adel", mem_o_adel, 1'b0);
    cpu_rst = 1'b0;

    alu_step(32'h1234, 1'b1);
    alu_step(32'hDEAD_BEEF, 1'b0);

    run_op(LB, 32'h103, 32'h0, 2, 32'h80FF_0000, -1, 0);
    run_op(SH, 32'h202, 32'h0000_ABCD, 0, 32'h0, -1, 0);
    run_op(LW, 32'h400, 32'h0, 2, 32'h1122_3344, 0, 0);
    run_op(LHU, 32'h502, 32'h0, 1, 32'h8765_4321, 1, 0);
    run_op(LH, 32'h602, 32'h0, 0, 32'h8765_4321, -1, 2);
    run_op(LBU, 32'h701, 32'h0, 0, 32'h0000_9A00, -1, 0);
`ifndef MEM_ALIGN_CHECK_EN
    run_op(LW, 32'h101, 32'h0, 0, 32'hCAFE_F00D, -1, 0);
    run_op(LH, 32'h103, 32'h0, 1, 32'hF00D_1234, -1, 0);
`endif

    // Flush while a memory op sits in IDLE: bubble, no request.
    @(posedge cpu_clk); #1;
    mem_i_memop = SW; mem_i_alures = 32'h800; mem_i_flush = 1'b1; #1;
    chk1("iflush_stall", stallreq_mem, 1'b0);
    chk1("iflush_req", dm_req, 1'b0);
    chk1("iflush_rfwe", mem_o_rfwe, 1'b0);
    chk("iflush_res", mem_o_res, ZERO);
    @(posedge cpu_clk); #1;
    mem_i_flush = 1'b0; mem_i_memop = NONE; #1;
    chk1("iflush_after_req", dm_req, 1'b0);

    // Reset in the middle of BUSY, then a stale ack.
    @(posedge cpu_clk); #1;
    mem_i_memop = LW; mem_i_alures = 32'h300; #1;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b1; #1;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    mem_i_memop = NONE; mem_i_alures = 32'h55; #1;
    chk1("rstb_req", dm_req, 1'b0);
    chk1("rstb_stall", stallreq_mem, 1'b0);
    chk("rstb_res", mem_o_res, 32'h55);
    @(posedge cpu_clk); #1;
    dm_ack = 1'b0; #1;
    chk("rstb_late_res", mem_o_res, 32'h55);
    chk1("rstb_late_req", dm_req, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    @(posedge cpu_clk); #1;
    mem_i_memop = LW; mem_i_alures = 32'h101; mem_i_rfwe = 1'b1; #1;
    chk1("adel", mem_o_adel, 1'b1);
    chk1("adel_ades", mem_o_ades, 1'b0);
    chk1("adel_stall", stallreq_mem, 1'b0);
    chk1("adel_req", dm_req, 1'b0);
    chk1("adel_rfwe", mem_o_rfwe, 1'b0);
    @(posedge cpu_clk); #1;
    mem_i_memop = SH; mem_i_alures = 32'h203; #1;
    chk1("ades", mem_o_ades, 1'b1);
    chk1("ades_req", dm_req, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if (is_half(op)) a = a & ~32'h1;
      else if (!is_byte(op)) a = a & ~32'h3;
`endif
      fl = ($urandom_range(0, 4) == 0) ? 0 : -1;
      run_op(op, a, $urandom, $urandom_range(0, 3), $urandom, fl, $urandom_range(0, 1));
    end
    alu_step(32'h0000_0F0F, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; widths come from the shared package types (reg_addr 5b, reg_word 32b, instr_addr 32b).
REQ-002 cpu_clk  in  1  single clock; all state updates on rising edge.
REQ-003 cpu_rst  in  1  synchronous reset, active-high.
REQ-004 mem_i_rfwe / mem_i_rfwa / mem_i_pc  in  1/5/32  write-enable, dest reg, PC from EX/MEM register.
REQ-005 mem_i_alures  in  32  ALU result; effective address for memory ops, else passthrough result.
REQ-006 mem_i_memop  in  memop_t  NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-007 mem_i_wdata  in  32  store data (rt).
REQ-008 mem_i_flush  in  1  discard instruction currently in MEM.
REQ-009 stall_i  in  1  stack stop bit for MEM (STOP/NOSTOP), external hold.
REQ-010 mem_o_rfwe / mem_o_rfwa / mem_o_res / mem_o_pc  out  1/5/32/32  to MEM/WB register.
REQ-011 stallreq_mem  out  1  request to stack controller to freeze stages 0..4.
REQ-012 dm_req / dm_we / dm_be / dm_addr / dm_wdata  out  1/1/4/32/32  data-memory request bus.
REQ-013 dm_ack / dm_rdata  in  1/32  one-cycle acknowledge; dm_rdata valid with dm_ack.
REQ-014 mem_o_adel / mem_o_ades  out  1/1  misaligned load / store exception flags.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; non-memory ops never leave IDLE and pass through combinationally (mem_o_res = mem_i_alures) with no stall.
REQ-016 IDLE with memop != NONE, no flush, aligned: stallreq_mem=1, next state BUSY; request fields registered at this edge.
REQ-017 BUSY: dm_req=1; dm_we/dm_be/dm_addr/dm_wdata held stable until dm_ack; stallreq_mem=1; on dm_ack load data captured in buffer, next state DONE.
REQ-018 DONE: stallreq_mem=0, outputs present the completed instruction; next state IDLE unless stall_i=STOP, in which case remain DONE with outputs stable.
REQ-019 Minimum MEM occupancy 3 cycles (IDLE, BUSY with immediate ack, DONE); each extra cycle without ack adds one.
REQ-020 dm_addr = {alures[31:2],2'b00}; dm_be: byte 4'b0001<<a[1:0], half 4'b0011<<{a[1],1'b0}, word 4'b1111; lane 0 = bits 7:0.
REQ-021 Stores replicate data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata; stores force mem_o_rfwe=0.
REQ-022 Loads select lane by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend to 32b.
REQ-023 While stallreq_mem=1, mem_o_rfwe=0 (bubble safety).
REQ-024 mem_i_flush in IDLE/DONE: outputs forced to rfwe=0, res/pc=ZERO, state IDLE; in BUSY: keep dm_req until dm_ack (no bus abandonment), set drop flag, then DONE emits a bubble.
REQ-025 Flush and dm_ack in same BUSY cycle: transaction completes, result dropped.
REQ-026 Store side effects are never retracted once dm_req asserted.

Reset
REQ-027 cpu_rst=1 at any edge, including mid-BUSY: state IDLE, dm_req=0, drop flag 0, load buffer ZERO, stallreq_mem=0, mem_o_rfwe=0, mem_o_rfwa=5'b0, mem_o_res/pc=ZERO, adel/ades=0; a pending ack is ignored.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with a[0]=1 or LW/SW with a[1:0]!=0 assert mem_o_adel (loads) or mem_o_ades (stores) combinationally in IDLE, no bus request, no stall, mem_o_rfwe=0.
REQ-029 Macro undefined: ports kept, adel/ades tied 0; halfword ignores a[0], word ignores a[1:0].

Structure
REQ-030 mips_abb_pkg gains memop_t, mem_state_t, byte_en (4b); reuses reg_addr, reg_word, instr_addr, ZERO, STOP, NOSTOP.
REQ-031 Lane steering/extension in combinational sub-module mem_align; FSM and buffer in mem_stage.

Verification
REQ-032 ALU op, memop NONE, alures 0x1234 -> same cycle mem_o_res=0x1234, stallreq_mem=0.
REQ-033 LB a=0x103, word 0x80FF_0000 acked 2 cycles late -> dm_be=4'b1000, stall 4 cycles, DONE res=0xFFFF_FF80.
REQ-034 SH a=0x202, wdata 0xABCD -> dm_be=4'b1100, dm_wdata=0xABCD_ABCD, mem_o_rfwe=0.
REQ-035 LW in BUSY, flush pulsed before ack -> dm_req held to ack, DONE rfwe=0.
REQ-036 cpu_rst mid-BUSY -> next cycle dm_req=0, state IDLE, late ack ignored.
REQ-037 MEM_ALIGN_CHECK_EN, LW a=0x101 -> adel=1, dm_req never asserted, no stall.
